// File: rtl/logo_pkg.sv
// Shared Q-glyph geometry and animation FSM encoding for the logo painter.
package logo_pkg;

  localparam int BAR_W    = 5;
  localparam int BAR_L    = 20;
  localparam int INSET    = 10;
  localparam int TAIL_OFF = 10;

  // Both end-of-travel pauses share ST_PAUSE; a separate direction bit tells them apart.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCROLL_R = 2'd1,
    ST_PAUSE    = 2'd2,
    ST_SCROLL_L = 2'd3
  } state_t;

  function automatic logic in_span(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/logo_anim_painter_q_glyph_hit.sv
// Combinational Q stroke-set test on signed glyph-local coordinates.
module q_glyph_hit
  import logo_pkg::*;
#(
  parameter int W = 11
) (
  input  logic signed [W:0] i_lx,
  input  logic signed [W:0] i_ly,
  output logic              o_hit
);

  logic signed [31:0] w_lx, w_ly, w_t, w_d;

  // Widen before subtracting so the tail diagonal cannot wrap for far-off pixels.
  assign w_lx = 32'(i_lx);
  assign w_ly = 32'(i_ly);
  assign w_t  = w_ly - TAIL_OFF;
  assign w_d  = w_lx - TAIL_OFF - w_t;

  assign o_hit = (in_span(w_lx, 0, BAR_W) && in_span(w_ly, 0, BAR_L))
              || (in_span(w_lx, 0, BAR_L) && in_span(w_ly, 0, BAR_W))
              || (in_span(w_lx, BAR_L, BAR_L + BAR_W) && in_span(w_ly, 0, BAR_L))
              || (in_span(w_lx, 0, BAR_L) && in_span(w_ly, BAR_L, BAR_L + BAR_W))
              || (in_span(w_t, 0, BAR_L) && in_span(w_d, 0, BAR_W));

endmodule

// File: rtl/logo_anim_painter.sv
// Paints GLYPH_N bouncing Q glyphs; hit/hit_idx follow x,y by exactly 2 cycles, never stalls.
module logo_anim_painter
  import logo_pkg::*;
#(
  parameter int COORD_W      = 11,
  parameter int ORIGIN_X     = 500,
  parameter int ORIGIN_Y     = 550,
  parameter int GLYPH_N      = 4,
  parameter int PITCH        = 40,
  parameter int STEP         = 2,
  parameter int DELT_MAX     = 100,
  parameter int PAUSE_FRAMES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               frame_start,
  input  logic [GLYPH_N-1:0] glyph_mask,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               hit,
  output logic [2:0]         hit_idx,
  output logic [COORD_W-1:0] delt,
  output logic [1:0]         state_o
);

  localparam int PC_W = $clog2(PAUSE_FRAMES) + 1;
  localparam logic [PC_W-1:0]    PF_LAST = PC_W'(PAUSE_FRAMES - 1);
  localparam logic [COORD_W-1:0] DMAX_L  = COORD_W'(DELT_MAX);
  localparam logic [COORD_W-1:0] STEP_L  = COORD_W'(STEP);
  localparam logic [COORD_W:0]   OY_L    = (COORD_W + 1)'(ORIGIN_Y + INSET);

  state_t              r_state, w_state_n;
  logic                r_at_left, w_at_left_n;
  logic [COORD_W-1:0]  r_delt, w_delt_n, w_delt_up, w_delt_dn;
  logic [PC_W-1:0]     r_pause_cnt, w_pause_cnt_n;

  assign w_delt_up = (r_delt >= DMAX_L - STEP_L) ? DMAX_L : r_delt + STEP_L;
  assign w_delt_dn = (r_delt <= STEP_L) ? '0 : r_delt - STEP_L;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_at_left   <= 1'b0;
      r_delt      <= '0;
      r_pause_cnt <= '0;
    end else begin
      r_state     <= w_state_n;
      r_at_left   <= w_at_left_n;
      r_delt      <= w_delt_n;
      r_pause_cnt <= w_pause_cnt_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_at_left_n   = r_at_left;
    w_delt_n      = r_delt;
    w_pause_cnt_n = r_pause_cnt;
    if (frame_start) begin
      if (!enable) begin
        w_state_n = ST_IDLE;
      end else begin
        unique case (r_state)
          // Leaving IDLE takes its first rightward step on the same pulse.
          ST_IDLE, ST_SCROLL_R: begin
            w_delt_n  = w_delt_up;
            w_state_n = ST_SCROLL_R;
            if (w_delt_up == DMAX_L) begin
              w_state_n     = ST_PAUSE;
              w_at_left_n   = 1'b0;
              w_pause_cnt_n = '0;
            end
          end
          ST_PAUSE: begin
            if (r_pause_cnt == PF_LAST) begin
              w_state_n = r_at_left ? ST_SCROLL_R : ST_SCROLL_L;
            end else begin
              w_pause_cnt_n = r_pause_cnt + 1'b1;
            end
          end
          ST_SCROLL_L: begin
            w_delt_n = w_delt_dn;
            if (w_delt_dn == '0) begin
              w_state_n     = ST_PAUSE;
              w_at_left_n   = 1'b1;
              w_pause_cnt_n = '0;
            end
          end
          default: w_state_n = ST_IDLE;
        endcase
      end
    end
  end

  logic signed [COORD_W:0]          w_lx_c [GLYPH_N];
  logic signed [COORD_W:0]          w_ly_c;
  logic [GLYPH_N-1:0][COORD_W:0]    r_lx;
  logic [COORD_W:0]                 r_ly;
  logic [GLYPH_N-1:0]               r_mask;
  logic                             r_en;
  logic [GLYPH_N-1:0]               w_shape, w_g_hit;
  logic [2:0]                       w_idx;
  logic                             w_any;
  logic                             r_hit;
  logic [2:0]                       r_idx;

  assign w_ly_c = $signed({1'b0, y}) - $signed(OY_L);

  for (genvar g = 0; g < GLYPH_N; g++) begin : g_glyph
    localparam logic [COORD_W:0] BASE = (COORD_W + 1)'(ORIGIN_X + INSET + g * PITCH);
    assign w_lx_c[g] = $signed({1'b0, x}) - $signed(BASE + {1'b0, r_delt});

    q_glyph_hit #(.W(COORD_W)) u_hit (
      .i_lx  ($signed(r_lx[g])),
      .i_ly  ($signed(r_ly)),
      .o_hit (w_shape[g])
    );
  end

  assign w_g_hit = w_shape & r_mask;
  assign w_any   = (|w_g_hit) & r_en;

  always_comb begin
    w_idx = '0;
    for (int i = GLYPH_N - 1; i >= 0; i--) begin
      if (w_g_hit[i]) w_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lx   <= '0;
      r_ly   <= '0;
      r_mask <= '0;
      r_en   <= 1'b0;
      r_hit  <= 1'b0;
      r_idx  <= '0;
    end else begin
      for (int i = 0; i < GLYPH_N; i++) r_lx[i] <= w_lx_c[i];
      r_ly   <= w_ly_c;
      r_mask <= glyph_mask;
      r_en   <= enable;
      r_hit  <= w_any;
      r_idx  <= w_any ? w_idx : 3'd0;
    end
  end

  assign hit     = r_hit;
  assign hit_idx = r_idx;
  assign delt    = r_delt;
  assign state_o = r_state;

endmodule

// File: tb/tb_logo_anim_painter.sv
// Randomized pixel stimulus and frame-pulse sequences checked against a behavioural model.
module tb_logo_anim_painter;

  localparam int CW = 11, OX = 500, OY = 550, GN = 4, PITCH = 40;
  localparam int STEP = 2, DMAX = 100, PF = 16;

  logic          clk = 0, rst = 1, enable = 0, frame_start = 0;
  logic [GN-1:0] glyph_mask = '0;
  logic [CW-1:0] x = '0, y = '0;
  logic          hit;
  logic [2:0]    hit_idx;
  logic [CW-1:0] delt;
  logic [1:0]    state_o;

  int total = 0, bad = 0;
  // Model: mode 0 idle, 1 right, 2 pause at right, 3 left, 4 pause at left.
  int m_delt = 0, m_mode = 0, m_cnt = 0;

  logo_anim_painter #(
    .COORD_W(CW), .ORIGIN_X(OX), .ORIGIN_Y(OY), .GLYPH_N(GN), .PITCH(PITCH),
    .STEP(STEP), .DELT_MAX(DMAX), .PAUSE_FRAMES(PF)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .glyph_mask(glyph_mask), .x(x), .y(y), .hit(hit), .hit_idx(hit_idx),
    .delt(delt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic int m_state_code();
    return (m_mode == 4) ? 2 : m_mode;
  endfunction

  function automatic logic on_q(input int lx, input int ly);
    int t;
    t = ly - 10;
    return (lx >= 0 && lx < 5  && ly >= 0  && ly < 20)
        || (lx >= 0 && lx < 20 && ly >= 0  && ly < 5)
        || (lx >= 20 && lx < 25 && ly >= 0 && ly < 20)
        || (lx >= 0 && lx < 20 && ly >= 20 && ly < 25)
        || (t >= 0 && t < 20 && (lx - 10 - t) >= 0 && (lx - 10 - t) < 5);
  endfunction

  function automatic void exp_pix(input int px, input int py, input int d, input logic [GN-1:0] msk,
                                  input logic en, output logic eh, output logic [2:0] ei);
    eh = 0; ei = 0;
    for (int i = GN - 1; i >= 0; i--) begin
      if (en && msk[i] && on_q(px - (OX + d + 10 + i * PITCH), py - (OY + 10))) begin
        eh = 1; ei = 3'(i);
      end
    end
  endfunction

  task automatic model_pulse();
    if (!enable) m_mode = 0;
    else case (m_mode)
      0, 1: begin
        m_delt = (m_delt + STEP > DMAX) ? DMAX : m_delt + STEP;
        if (m_delt == DMAX) begin m_mode = 2; m_cnt = 0; end else m_mode = 1;
      end
      2, 4: begin
        if (m_cnt == PF - 1) m_mode = (m_mode == 2) ? 3 : 1;
        else m_cnt++;
      end
      default: begin
        m_delt = (m_delt - STEP < 0) ? 0 : m_delt - STEP;
        if (m_delt == 0) begin m_mode = 4; m_cnt = 0; end
      end
    endcase
  endtask

  task automatic pulse();
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    model_pulse();
  endtask

  task automatic probe(input int px, input int py, output logic h1, output logic h2, output logic [2:0] i2);
    @(posedge clk); #1 x = CW'(px); y = CW'(py);
    @(posedge clk); #1 h1 = hit;
    @(posedge clk); #1 h2 = hit; i2 = hit_idx;
  endtask

  task automatic test_reset();
    #2;
    total++; if (hit !== 1'b0 || hit_idx !== 3'd0) begin bad++; $display("FAIL reset_hit: got %b/%0d want 0/0", hit, hit_idx); end
    total++; if (delt !== '0 || state_o !== 2'd0) begin bad++; $display("FAIL reset_fsm: got delt=%0d st=%0d want 0/0", delt, state_o); end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_latency();
    logic h1, h2; logic [2:0] i2, ei; logic eh;
    enable = 1; glyph_mask = 4'b0001;
    probe(0, 0, h1, h2, i2);
    probe(512, 565, h1, h2, i2);
    total++; if (h1 !== 1'b0) begin bad++; $display("FAIL latency_early: got %b at 1 cycle want 0", h1); end
    total++; if (h2 !== 1'b1 || i2 !== 3'd0) begin bad++; $display("FAIL left_bar: got %b/%0d want 1/0", h2, i2); end
    probe(509, 565, h1, h2, i2);
    total++; if (h2 !== 1'b0) begin bad++; $display("FAIL left_of_glyph: got %b want 0", h2); end
    glyph_mask = 4'b0110;
    probe(552, 562, h1, h2, i2);
    total++; if (h2 !== 1'b1 || i2 !== 3'd1) begin bad++; $display("FAIL g1_top: got %b/%0d want 1/1", h2, i2); end
    glyph_mask = 4'b0100;
    probe(552, 562, h1, h2, i2);
    total++; if (h2 !== 1'b0 || i2 !== 3'd0) begin bad++; $display("FAIL g1_masked: got %b/%0d want 0/0", h2, i2); end
    glyph_mask = 4'b1111;
    probe(522, 572, h1, h2, i2);
    exp_pix(522, 572, 0, glyph_mask, 1, eh, ei);
    total++; if (h2 !== 1'b1 || h2 !== eh) begin bad++; $display("FAIL tail_in: got %b want 1", h2); end
    probe(528, 572, h1, h2, i2);
    total++; if (h2 !== 1'b0) begin bad++; $display("FAIL tail_out: got %b want 0", h2); end
  endtask

  task automatic test_bounds();
    logic h1, h2; logic [2:0] i2;
    int px[4] = '{2047, 2047, 0, 1540};
    int py[4] = '{2047, 565, 565, 2047};
    glyph_mask = 4'b1111; enable = 1;
    for (int k = 0; k < 4; k++) begin
      probe(px[k], py[k], h1, h2, i2);
      total++; if (h2 !== 1'b0 || i2 !== 3'd0) begin bad++; $display("FAIL bound_%0d: got %b/%0d want 0/0", k, h2, i2); end
    end
  endtask

  task automatic test_random_pixels(input int n);
    logic eh_q[$]; logic [2:0] ei_q[$];
    logic eh; logic [2:0] ei;
    for (int i = 0; i < n + 2; i++) begin
      @(posedge clk); #1;
      if (i >= 2) begin
        eh = eh_q.pop_front(); ei = ei_q.pop_front();
        total++;
        if (hit !== eh || hit_idx !== ei) begin
          bad++; $display("FAIL rand_pix_%0d: got %b/%0d want %b/%0d (delt=%0d)", i - 2, hit, hit_idx, eh, ei, m_delt);
        end
      end
      if (i < n) begin
        if ($urandom_range(0, 3) != 0) begin
          x = CW'(OX + m_delt + $urandom_range(0, GN * PITCH + 12));
          y = CW'(OY + $urandom_range(0, 45));
        end else begin
          x = CW'($urandom_range(0, 2047));
          y = CW'($urandom_range(0, 2047));
        end
        glyph_mask = GN'($urandom_range(0, 15));
        enable = ($urandom_range(0, 7) != 0);
        exp_pix(int'(x), int'(y), m_delt, glyph_mask, enable, eh, ei);
        eh_q.push_back(eh); ei_q.push_back(ei);
      end
    end
    enable = 1;
  endtask

  task automatic test_scroll();
    enable = 1;
    for (int i = 0; i < 50; i++) begin
      pulse();
      total++;
      if (int'(delt) != m_delt || int'(state_o) != m_state_code()) begin
        bad++; $display("FAIL scroll_r_%0d: got delt=%0d st=%0d want %0d/%0d", i, delt, state_o, m_delt, m_state_code());
      end
    end
    total++; if (delt !== CW'(100) || state_o !== 2'd2) begin bad++; $display("FAIL reach_max: got %0d/%0d want 100/2", delt, state_o); end
    test_random_pixels(60);
    for (int i = 0; i < 16; i++) pulse();
    total++; if (delt !== CW'(100) || state_o !== 2'd3) begin bad++; $display("FAIL pause_end: got %0d/%0d want 100/3", delt, state_o); end
    pulse();
    total++; if (delt !== CW'(98) || state_o !== 2'd3) begin bad++; $display("FAIL first_left: got %0d/%0d want 98/3", delt, state_o); end
  endtask

  task automatic test_disable();
    logic h1, h2; logic [2:0] i2;
    for (int i = 0; i < 100 && m_delt != 40; i++) pulse();
    enable = 0;
    pulse();
    total++; if (delt !== CW'(40) || state_o !== 2'd0) begin bad++; $display("FAIL disable: got %0d/%0d want 40/0", delt, state_o); end
    glyph_mask = 4'b1111;
    probe(552, 565, h1, h2, i2);
    total++; if (h2 !== 1'b0) begin bad++; $display("FAIL disabled_hit: got %b want 0", h2); end
    pulse();
    total++; if (delt !== CW'(40) || state_o !== 2'd0) begin bad++; $display("FAIL idle_hold: got %0d/%0d want 40/0", delt, state_o); end
    enable = 1;
    pulse();
    total++; if (delt !== CW'(42) || state_o !== 2'd1) begin bad++; $display("FAIL resume: got %0d/%0d want 42/1", delt, state_o); end
    probe(554, 565, h1, h2, i2);
    total++; if (h2 !== 1'b1 || i2 !== 3'd0) begin bad++; $display("FAIL resumed_hit: got %b/%0d want 1/0", h2, i2); end
  endtask

  task automatic test_async_reset();
    logic h1, h2; logic [2:0] i2, ei; logic eh;
    for (int i = 0; i < 100 && m_delt != 60; i++) pulse();
    total++; if (delt !== CW'(60)) begin bad++; $display("FAIL pre_rst_delt: got %0d want 60", delt); end
    glyph_mask = 4'b0001;
    probe(572, 565, h1, h2, i2);
    total++; if (h2 !== 1'b1) begin bad++; $display("FAIL pre_rst_hit: got %b want 1", h2); end
    @(posedge clk); #3 rst = 1;
    #1;
    total++; if (hit !== 1'b0 || hit_idx !== 3'd0) begin bad++; $display("FAIL async_rst_hit: got %b/%0d want 0/0", hit, hit_idx); end
    total++; if (delt !== '0 || state_o !== 2'd0) begin bad++; $display("FAIL async_rst_fsm: got %0d/%0d want 0/0", delt, state_o); end
    m_delt = 0; m_mode = 0; m_cnt = 0;
    @(negedge clk); rst = 0;
    probe(512, 565, h1, h2, i2);
    exp_pix(512, 565, m_delt, glyph_mask, enable, eh, ei);
    total++; if (h2 !== eh || i2 !== ei) begin bad++; $display("FAIL post_rst: got %b/%0d want %b/%0d", h2, i2, eh, ei); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounds();
    test_random_pixels(200);
    test_scroll();
    test_disable();
    test_random_pixels(100);
    test_async_reset();
    test_random_pixels(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
